// File: rtl/cond_exec_unit.sv
// Execute-stage condition unit: NZCV flag register, condition evaluation,
// write-enable gating and a Thumb-style IT block tracker.
module cond_exec_unit #(
    parameter int unsigned FLAGWR_W = 2,
    parameter bit          NV_MODE  = 1'b0,
    parameter bit          IT_EN    = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                StallE,
    input  logic                FlushE,
    input  logic [3:0]          CondE,
    input  logic [FLAGWR_W-1:0] FlagWriteE,
    input  logic [3:0]          ALUFlags,
    input  logic                PCSrcE,
    input  logic                RegWriteE,
    input  logic                MemWriteE,
    input  logic                ITLoadE,
    input  logic [3:0]          ITFirstCond,
    input  logic [2:0]          ITLen,
    input  logic [3:0]          ITPattern,
    output logic                CondExE,
    output logic                PCSrcOut,
    output logic                RegWriteOut,
    output logic                MemWriteOut,
    output logic [3:0]          Flags,
    output logic                InITBlock,
    output logic [2:0]          ITCount
);
    logic [3:0] flags_q;
    logic [3:0] flag_mask;
    logic [3:0] it_pattern_q;
    logic [3:0] it_base_q;
    logic [3:0] eff_cond;
    logic [2:0] it_count_q;
    logic [2:0] it_len_clamped;
    logic       it_load;
    logic       it_active;
    logic       force_false;
    logic       cond_pass;
    logic       advance;

    generate
        if (FLAGWR_W == 2) begin : g_fw2
            assign flag_mask = {FlagWriteE[1], FlagWriteE[1], FlagWriteE[0], FlagWriteE[0]};
        end else if (FLAGWR_W == 4) begin : g_fw4
            assign flag_mask = FlagWriteE;
        end else begin : g_fw_bad
            $error("cond_exec_unit: FLAGWR_W must be 2 or 4");
        end
    endgenerate

    function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'b0000: eval_cond = z;
            4'b0001: eval_cond = !z;
            4'b0010: eval_cond = cf;
            4'b0011: eval_cond = !cf;
            4'b0100: eval_cond = n;
            4'b0101: eval_cond = !n;
            4'b0110: eval_cond = v;
            4'b0111: eval_cond = !v;
            4'b1000: eval_cond = cf && !z;
            4'b1001: eval_cond = !(cf && !z);
            4'b1010: eval_cond = (n == v);
            4'b1011: eval_cond = (n != v);
            4'b1100: eval_cond = !z && (n == v);
            4'b1101: eval_cond = !(!z && (n == v));
            4'b1110: eval_cond = 1'b1;
            default: eval_cond = NV_MODE;
        endcase
    endfunction

    assign it_load        = IT_EN && ITLoadE;
    assign advance        = !StallE && !FlushE;
    assign it_len_clamped = (ITLen > 3'd4) ? 3'd4 : ITLen;

    // Inside a block the slot condition replaces CondE; an Else slot of AL never executes.
    always_comb begin
        it_active   = (it_count_q != 3'd0);
        force_false = 1'b0;
        eff_cond    = CondE;
        if (it_active) begin
            if (it_pattern_q[0]) begin
                eff_cond = it_base_q;
            end else begin
                eff_cond    = {it_base_q[3:1], ~it_base_q[0]};
                force_false = (it_base_q == 4'b1110);
            end
        end
        cond_pass = eval_cond(eff_cond, flags_q) && !force_false;
        if (FlushE)
            CondExE = 1'b0;
        else if (it_load)
            CondExE = 1'b1;
        else
            CondExE = cond_pass;
    end

    assign PCSrcOut    = PCSrcE && CondExE;
    assign RegWriteOut = RegWriteE && CondExE;
    assign MemWriteOut = MemWriteE && CondExE;
    assign Flags       = flags_q;
    assign ITCount     = it_count_q;
    assign InITBlock   = it_active;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q      <= '0;
            it_count_q   <= '0;
            it_pattern_q <= '0;
            it_base_q    <= '0;
        end else if (advance) begin
            if (CondExE)
                flags_q <= (flags_q & ~flag_mask) | (ALUFlags & flag_mask);
            // A new IT load abandons any block in progress; a taken branch aborts it.
            if (it_load) begin
                if (ITLen != 3'd0) begin
                    it_count_q   <= it_len_clamped;
                    it_pattern_q <= ITPattern | 4'b0001;
                    it_base_q    <= ITFirstCond;
                end
            end else if (it_active) begin
                it_count_q   <= PCSrcOut ? 3'd0 : it_count_q - 3'd1;
                it_pattern_q <= {1'b0, it_pattern_q[3:1]};
            end
        end
    end
endmodule

// File: tb/tb_cond_exec_unit.sv
// Vector-table and scoreboard bench for cond_exec_unit; a second instance
// exercises 4-group flag writes with NV_MODE=1.
module tb_cond_exec_unit;
    logic       clk, reset, StallE, FlushE, PCSrcE, RegWriteE, MemWriteE, ITLoadE;
    logic [3:0] CondE, ALUFlags, ITFirstCond, ITPattern, fw4;
    logic [1:0] FlagWriteE;
    logic [2:0] ITLen;
    logic       CondExE, PCSrcOut, RegWriteOut, MemWriteOut, InITBlock;
    logic [3:0] Flags;
    logic [2:0] ITCount;
    logic       cex4, pc4, rw4, mw4, init4;
    logic [3:0] flags4;
    logic [2:0] cnt4;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      name;
        logic       st, fl;
        logic [3:0] cond;
        logic [1:0] fw;
        logic [3:0] alu;
        logic [2:0] gates;    // {PCSrcE, RegWriteE, MemWriteE}
        logic       ld;
        logic [3:0] itc;
        logic [2:0] itlen;
        logic [3:0] itpat;
        logic [3:0] exp_out;  // {CondExE, PCSrcOut, RegWriteOut, MemWriteOut}
        logic [3:0] ef;
        logic [2:0] ec;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    logic [3:0] flag_set[8];

    cond_exec_unit #(.FLAGWR_W(2), .NV_MODE(1'b0), .IT_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .CondE(CondE),
        .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags), .PCSrcE(PCSrcE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ITLoadE(ITLoadE),
        .ITFirstCond(ITFirstCond), .ITLen(ITLen), .ITPattern(ITPattern),
        .CondExE(CondExE), .PCSrcOut(PCSrcOut), .RegWriteOut(RegWriteOut),
        .MemWriteOut(MemWriteOut), .Flags(Flags), .InITBlock(InITBlock), .ITCount(ITCount)
    );

    cond_exec_unit #(.FLAGWR_W(4), .NV_MODE(1'b1), .IT_EN(1'b1)) u_dut4 (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .CondE(CondE),
        .FlagWriteE(fw4), .ALUFlags(ALUFlags), .PCSrcE(PCSrcE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ITLoadE(ITLoadE),
        .ITFirstCond(ITFirstCond), .ITLen(ITLen), .ITPattern(ITPattern),
        .CondExE(cex4), .PCSrcOut(pc4), .RegWriteOut(rw4),
        .MemWriteOut(mw4), .Flags(flags4), .InITBlock(init4), .ITCount(cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t v(input string nm, input logic st, input logic fl,
                               input logic [3:0] cond, input logic [1:0] fw, input logic [3:0] alu,
                               input logic [2:0] gates, input logic ld, input logic [3:0] itc,
                               input logic [2:0] itlen, input logic [3:0] itpat,
                               input logic [3:0] exp_out, input logic [3:0] ef, input logic [2:0] ec);
        vec_t r;
        r.name = nm; r.st = st; r.fl = fl; r.cond = cond; r.fw = fw; r.alu = alu;
        r.gates = gates; r.ld = ld; r.itc = itc; r.itlen = itlen; r.itpat = itpat;
        r.exp_out = exp_out; r.ef = ef; r.ec = ec;
        return r;
    endfunction

    // ARM-style reference: pair of conditions selected by cond[3:1], cond[0] inverts.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, vv, base;
        n = f[3]; z = f[2]; cf = f[1]; vv = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = vv;
            3'd4: base = cf && !z;
            3'd5: base = (n == vv);
            3'd6: base = !z && (n == vv);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        StallE = 1'b0; FlushE = 1'b0; CondE = 4'hE; FlagWriteE = 2'b00; fw4 = 4'h0;
        ALUFlags = 4'h0; PCSrcE = 1'b0; RegWriteE = 1'b0; MemWriteE = 1'b0;
        ITLoadE = 1'b0; ITFirstCond = 4'h0; ITLen = 3'd0; ITPattern = 4'h0;
    endtask

    task automatic step(input vec_t t);
        vec_t e;
        StallE = t.st; FlushE = t.fl; CondE = t.cond; FlagWriteE = t.fw; ALUFlags = t.alu;
        {PCSrcE, RegWriteE, MemWriteE} = t.gates;
        ITLoadE = t.ld; ITFirstCond = t.itc; ITLen = t.itlen; ITPattern = t.itpat;
        exp_q.push_back(t);
        #2;
        e = exp_q.pop_front();
        chk({e.name, ".out"}, {CondExE, PCSrcOut, RegWriteOut, MemWriteOut}, e.exp_out);
        @(posedge clk); #1;
        chk({e.name, ".flags"}, Flags, e.ef);
        chk({e.name, ".cnt"}, {1'b0, ITCount}, {1'b0, e.ec});
        chk({e.name, ".init"}, {3'b000, InITBlock}, {3'b000, e.ec != 3'd0});
    endtask

    task automatic step4(input string nm, input logic [3:0] cond, input logic [3:0] fw,
                         input logic [3:0] alu, input logic exp_cex, input logic [3:0] exp_f);
        drive_idle();
        CondE = cond; fw4 = fw; ALUFlags = alu;
        #2;
        chk({nm, ".cex4"}, {3'b000, cex4}, {3'b000, exp_cex});
        @(posedge clk); #1;
        chk({nm, ".flags4"}, flags4, exp_f);
    endtask

    initial begin
        // name st fl cond fw alu gates ld itc len pat | out flags cnt
        tbl.push_back(v("al_all",      0,0,4'hE,2'b00,4'h0,3'b111,0,4'h0,3'd0,4'h0, 4'b1111,4'h0,3'd0));
        tbl.push_back(v("eq_z0",       0,0,4'h0,2'b00,4'h0,3'b010,0,4'h0,3'd0,4'h0, 4'b0000,4'h0,3'd0));
        tbl.push_back(v("fw01",        0,0,4'hE,2'b01,4'hF,3'b000,0,4'h0,3'd0,4'h0, 4'b1000,4'h3,3'd0));
        tbl.push_back(v("fw10_ne",     0,0,4'h1,2'b10,4'hF,3'b000,0,4'h0,3'd0,4'h0, 4'b1000,4'hF,3'd0));
        tbl.push_back(v("set_z",       0,0,4'hE,2'b11,4'h4,3'b000,0,4'h0,3'd0,4'h0, 4'b1000,4'h4,3'd0));
        tbl.push_back(v("fail_nowr",   0,0,4'h1,2'b11,4'hA,3'b010,0,4'h0,3'd0,4'h0, 4'b0000,4'h4,3'd0));
        tbl.push_back(v("flush_nowr",  0,1,4'hE,2'b11,4'hA,3'b010,0,4'h0,3'd0,4'h0, 4'b0000,4'h4,3'd0));
        tbl.push_back(v("stall_nowr",  1,0,4'hE,2'b11,4'hA,3'b010,0,4'h0,3'd0,4'h0, 4'b1010,4'h4,3'd0));
        tbl.push_back(v("it_load",     0,0,4'h1,2'b00,4'h0,3'b000,1,4'h0,3'd3,4'h5, 4'b1000,4'h4,3'd3));
        tbl.push_back(v("it_s0",       0,0,4'hE,2'b00,4'h0,3'b010,0,4'h0,3'd0,4'h0, 4'b1010,4'h4,3'd2));
        tbl.push_back(v("it_s1_stall", 1,0,4'hE,2'b00,4'h0,3'b010,0,4'h0,3'd0,4'h0, 4'b0000,4'h4,3'd2));
        tbl.push_back(v("it_s1_flush", 0,1,4'hE,2'b00,4'h0,3'b010,0,4'h0,3'd0,4'h0, 4'b0000,4'h4,3'd2));
        tbl.push_back(v("it_s1",       0,0,4'hE,2'b00,4'h0,3'b010,0,4'h0,3'd0,4'h0, 4'b0000,4'h4,3'd1));
        tbl.push_back(v("it_s2",       0,0,4'hE,2'b00,4'h0,3'b010,0,4'h0,3'd0,4'h0, 4'b1010,4'h4,3'd0));
        tbl.push_back(v("post_it",     0,0,4'h1,2'b00,4'h0,3'b010,0,4'h0,3'd0,4'h0, 4'b0000,4'h4,3'd0));
        tbl.push_back(v("ab_load",     0,0,4'hE,2'b00,4'h0,3'b000,1,4'h0,3'd3,4'h7, 4'b1000,4'h4,3'd3));
        tbl.push_back(v("ab_br",       0,0,4'h0,2'b00,4'h0,3'b100,0,4'h0,3'd0,4'h0, 4'b1100,4'h4,3'd0));
        tbl.push_back(v("ab_after",    0,0,4'hE,2'b00,4'h0,3'b010,0,4'h0,3'd0,4'h0, 4'b1010,4'h4,3'd0));
        tbl.push_back(v("clamp_load",  0,0,4'hE,2'b00,4'h0,3'b000,1,4'hE,3'd7,4'h0, 4'b1000,4'h4,3'd4));
        tbl.push_back(v("al_then",     0,0,4'hE,2'b00,4'h0,3'b010,0,4'h0,3'd0,4'h0, 4'b1010,4'h4,3'd3));
        tbl.push_back(v("al_else",     0,0,4'hE,2'b00,4'h0,3'b010,0,4'h0,3'd0,4'h0, 4'b0000,4'h4,3'd2));
        tbl.push_back(v("reload",      0,0,4'hE,2'b00,4'h0,3'b000,1,4'h1,3'd1,4'h0, 4'b1000,4'h4,3'd1));
        tbl.push_back(v("ne_then",     0,0,4'hE,2'b00,4'h0,3'b010,0,4'h0,3'd0,4'h0, 4'b0000,4'h4,3'd0));
        tbl.push_back(v("len0",        0,0,4'h1,2'b00,4'h0,3'b000,1,4'h0,3'd0,4'hF, 4'b1000,4'h4,3'd0));
        tbl.push_back(v("len0_after",  0,0,4'h0,2'b00,4'h0,3'b010,0,4'h0,3'd0,4'h0, 4'b1010,4'h4,3'd0));
        tbl.push_back(v("fb_load",     0,0,4'hE,2'b00,4'h0,3'b000,1,4'h1,3'd2,4'h1, 4'b1000,4'h4,3'd2));
        tbl.push_back(v("fb_br_fail",  0,0,4'hE,2'b00,4'h0,3'b100,0,4'h0,3'd0,4'h0, 4'b0000,4'h4,3'd1));
        tbl.push_back(v("fb_else",     0,0,4'hE,2'b00,4'h0,3'b010,0,4'h0,3'd0,4'h0, 4'b1010,4'h4,3'd0));
        tbl.push_back(v("nv_never",    0,0,4'hF,2'b00,4'h0,3'b111,0,4'h0,3'd0,4'h0, 4'b0000,4'h4,3'd0));
        tbl.push_back(v("stall_load",  1,0,4'h1,2'b00,4'h0,3'b000,1,4'h0,3'd2,4'h0, 4'b1000,4'h4,3'd0));
        tbl.push_back(v("flush_load",  0,1,4'h1,2'b00,4'h0,3'b000,1,4'h0,3'd2,4'h0, 4'b0000,4'h4,3'd0));
        tbl.push_back(v("itfw_load",   0,0,4'hE,2'b00,4'h0,3'b000,1,4'h1,3'd1,4'h0, 4'b1000,4'h4,3'd1));
        tbl.push_back(v("itfw_slot",   0,0,4'hE,2'b11,4'h0,3'b010,0,4'h0,3'd0,4'h0, 4'b0000,4'h4,3'd0));

        flag_set[0] = 4'h0; flag_set[1] = 4'hF; flag_set[2] = 4'h9; flag_set[3] = 4'h6;
        flag_set[4] = 4'h8; flag_set[5] = 4'h2; flag_set[6] = 4'h4; flag_set[7] = 4'h1;

        reset = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.flags", Flags, 4'h0);
        chk("rst.cnt", {1'b0, ITCount}, 4'h0);
        chk("rst.init", {3'b000, InITBlock}, 4'h0);
        reset = 1'b1;

        foreach (tbl[i]) step(tbl[i]);

        // Full condition table against a range of flag values.
        foreach (flag_set[k]) begin
            step(v("cl_set",0,0,4'hE,2'b11,flag_set[k],3'b000,0,4'h0,3'd0,4'h0, 4'b1000,flag_set[k],3'd0));
            FlagWriteE = 2'b00;
            for (int c = 0; c < 16; c++) begin
                CondE = c[3:0];
                #1;
                chk($sformatf("cond_%h_f%h", c[3:0], flag_set[k]), {3'b000, CondExE},
                    {3'b000, ref_pass(c[3:0], flag_set[k])});
            end
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of an IT block.
        step(v("pre_f",  0,0,4'hE,2'b11,4'hF,3'b000,0,4'h0,3'd0,4'h0, 4'b1000,4'hF,3'd0));
        step(v("pre_ld", 0,0,4'hE,2'b00,4'h0,3'b000,1,4'hE,3'd3,4'h0, 4'b1000,4'hF,3'd3));
        step(v("pre_s0", 0,0,4'hE,2'b00,4'h0,3'b000,0,4'h0,3'd0,4'h0, 4'b1000,4'hF,3'd2));
        drive_idle();
        #2;
        reset = 1'b0;
        #1;
        chk("arst.flags", Flags, 4'h0);
        chk("arst.cnt", {1'b0, ITCount}, 4'h0);
        chk("arst.init", {3'b000, InITBlock}, 4'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        step(v("rel_eq", 0,0,4'h0,2'b00,4'h0,3'b010,0,4'h0,3'd0,4'h0, 4'b0000,4'h0,3'd0));

        // Four-group flag writes and NV treated as always.
        step4("w4_z_nv",  4'hF, 4'b0100, 4'hF, 1'b1, 4'b0100);
        chk("w4_main_nv", {3'b000, CondExE}, 4'h0);
        step4("w4_nv_eq", 4'h0, 4'b1001, 4'hF, 1'b1, 4'b1101);
        step4("w4_cs_no", 4'h2, 4'b0010, 4'hF, 1'b0, 4'b1101);
        step4("w4_c",     4'hF, 4'b0010, 4'hF, 1'b1, 4'b1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cond_exec_unit.md
Name: cond_exec_unit

Overview:
- Execute-stage condition unit for the pipelined ARM core.
- Holds the architectural NZCV flag register and evaluates the 4-bit condition field against it.
- Gates PCSrc/RegWrite/MemWrite and applies masked flag updates.
- Adds a Thumb-style IT predication block tracker, stall/flush handling and a parametrised flag-write granularity.

Parameters:
- FLAGWR_W, 2, flag-write groups. 2: bit1→N,Z and bit0→C,V. 4: bit3→N, bit2→Z, bit1→C, bit0→V. Any other value is an elaboration error.
- NV_MODE, 0, behaviour of cond 1111. 0 = never (CondExE=0). 1 = always (unconditional space).
- IT_EN, 1, 1 = IT tracker present. 0 = ITLoadE ignored and ITCount tied to 0.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- StallE  in  1  hold all state this cycle
- FlushE  in  1  instruction in E is a bubble
- CondE  in  4  instruction condition field
- FlagWriteE  in  FLAGWR_W  flag-write group enables
- ALUFlags  in  4  {N,Z,C,V} from the ALU
- PCSrcE  in  1  branch/PC write request
- RegWriteE  in  1  register write request
- MemWriteE  in  1  memory write request
- ITLoadE  in  1  instruction in E is an IT instruction
- ITFirstCond  in  4  IT base condition
- ITLen  in  3  IT block length, 1..4
- ITPattern  in  4  bit i: 1 = Then, 0 = Else for slot i; bit0 forced Then
- CondExE  out  1  condition passed, qualified by FlushE
- PCSrcOut  out  1  PCSrcE & CondExE
- RegWriteOut  out  1  RegWriteE & CondExE
- MemWriteOut  out  1  MemWriteE & CondExE
- Flags  out  4  registered {N,Z,C,V}
- InITBlock  out  1  ITCount != 0
- ITCount  out  3  remaining IT slots

Behaviour:
- Reset (reset=0, asynchronous): Flags=0000, ITCount=0, IT pattern register=0000, IT base condition register=0000.
- After reset, outputs are combinational from the inputs and state; there is no internal latency.
- Effective condition, IT inactive: CondE.
- Effective condition, IT active: base condition for a Then slot. For an Else slot, base condition with bit0 inverted.
- Base condition 1110 with an Else slot: slot evaluates false.
- Condition table (from registered Flags):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !(C&!Z); GE N==V; LT N!=V.
  - GT !Z&(N==V); LE !(!Z&(N==V)); AL 1.
  - 1111 per NV_MODE.
- FlushE=1: CondExE and the three gated outputs are 0.
- ITLoadE: the IT instruction itself is unpredicated. Its CondExE = !FlushE, independent of CondE.
- Flag update at the clock edge when StallE=0, FlushE=0 and CondExE=1: each group with its enable set loads its ALUFlags bits; other bits hold.
- No update if the condition fails, FlushE=1, or StallE=1.
- A flag write takes effect for the next instruction. No internal forwarding.
- IT load (StallE=0, FlushE=0, ITLoadE=1, IT_EN=1): next cycle ITCount=ITLen and the pattern/base condition registers are loaded.
  - ITLen=0 or >4 is clamped: 0→no load, >4→4.
  - ITLoadE while already in a block: the new load wins and the old block is abandoned.
- IT consume (StallE=0, FlushE=0, ITCount!=0, ITLoadE=0): ITCount decrements by 1 and the pattern shifts right by 1. This happens whether the slot passed or failed.
- IT abort: PCSrcOut=1 inside a block (taken branch) clears ITCount to 0 at the edge, overriding the decrement.
- StallE=1 holds all state, takes priority over FlushE for state, and leaves the combinational outputs live.
- A flushed slot does not consume an IT slot.
- An asynchronous reset mid-block clears state immediately, without waiting for a clock edge.

Test Plan:
- Reset, then CondE=1110, PCSrcE=RegWriteE=MemWriteE=1 → all outputs 1. Then CondE=0000 → CondExE=0, since Z=0.
- FLAGWR_W=2, Flags=0000: ALUFlags=1111, FlagWriteE=01, CondE=1110 → Flags=0011. Next, FlagWriteE=10, CondE=0001 → Flags=1111.
- Flags=0100, CondE=0001, FlagWriteE=11, ALUFlags=1010, RegWriteE=1 → RegWriteOut=0 and Flags stays 0100. Repeat with FlushE=1 and CondE=1110 → same result.
- Flags Z=1: ITLoadE with ITFirstCond=0000, ITLen=3, ITPattern=0101 → following slots give CondExE=1,0,1 and ITCount=3,2,1,0.
  - Insert StallE=1 at slot 2 → ITCount holds at 2.
  - Insert FlushE=1 at slot 2 → ITCount holds at 2.
- In an IT block with ITCount=3, PCSrcE=1 passing → ITCount=0 next cycle. The following CondE=1110 instruction executes.
- Pull reset low mid-cycle with Flags=1111 and ITCount=2 → Flags=0000 and ITCount=0 before the next edge. After release, CondE=0000 gives CondExE=0.
